riscv_intr_ctrl: RTL and testbench
==================================

# riscv_intr_ctrl

Memory-mapped timer and interrupt controller for the 3-stage pipelined RISC-V core. Generates the core's timer interrupt (`t_intr`) from a prescaled free-running `mtime`/`mtimecmp` comparator. Generates the external interrupt (`e_intr`) from a synchronized, edge-detected, latched external request line. Sits on the core's data-memory bus as a slave, beside `data_mem`. Its interrupt outputs drive the core's `t_intr`/`e_intr` inputs, which feed the CSR `mip` logic.

## Interface
- `DW`, 32, data/register width
- `ADDRW`, 12, bus address width; only `addr_i[3:2]` is decoded
- `clk_i` in 1: single clock, rising edge
- `rst_i` in 1: reset, synchronous, active-low
- `sel_i` in 1: slave select, one-cycle access strobe
- `we_i` in 1: 1 = write, 0 = read
- `addr_i` in ADDRW: byte address
- `wdata_i` in DW: write data
- `rdata_o` out DW: registered read data
- `rvalid_o` out 1: read data valid, one-cycle pulse
- `ext_irq_i` in 1: asynchronous external interrupt request
- `e_ack_i` in 1: core trap-entry acknowledge for the external interrupt
- `t_intr_o` out 1: timer interrupt, level
- `e_intr_o` out 1: external interrupt, level

## Operation
- Register map (`addr_i[3:2]`):
  - 0 `MTIME`, RW
  - 1 `MTIMECMP`, RW
  - 2 `CTRL`, RW: bit0 `timer_en`, bit1 `ext_en`, bits[15:8] `prescale`; other bits read 0
  - 3 `PEND`, read / write-1-to-clear: bit0 `tp` (read-only mirror of the timer compare), bit1 `ep`
- Reset values: `mtime`=0, `mtimecmp`=all ones, `CTRL`=0, `ep`=0, prescale counter=0, synchronizer flops=0, `rdata_o`=0, `rvalid_o`=0, `t_intr_o`=0, `e_intr_o`=0.
- Prescaler:
  - The counter runs only while `timer_en`=1.
  - When counter == `prescale`: counter clears to 0 and `mtime` increments. With `prescale`=0, `mtime` increments every cycle.
  - Otherwise the counter increments.
- `mtime` wraps from 2^DW-1 to 0 with no flag.
- Writing `CTRL` resets the prescale counter to 0.
- Timer compare: `tp` = (`mtime` >= `mtimecmp`, unsigned) & `timer_en`. It is level-sensitive. Software clears it by raising `MTIMECMP` or by clearing `timer_en`.
- External path:
  - `ext_irq_i` passes through a 2-flop synchronizer, then a rising-edge detector.
  - A detected edge sets `ep` while `ext_en`=1. Edges are ignored while `ext_en`=0.
  - `ep` clears on a `PEND` write with bit1=1, or on `e_ack_i`=1.
- Priority:
  - A bus write to `MTIME` in the same cycle as a prescale tick: the write wins, so `mtime`=`wdata_i`.
  - An `ep` set in the same cycle as an `ep` clear: the set wins, so no edge is lost.
- Bus:
  - Reads return the register value as of the `sel_i` cycle.
  - Writes take effect at the same clock edge.
  - Unmapped bits read 0.
  - Bits of `addr_i` other than [3:2] are ignored.

## Timing
- Read: `sel_i`&!`we_i` sampled at edge k → `rdata_o` valid with `rvalid_o`=1 after edge k, for exactly one cycle. `rvalid_o`=0 otherwise. `rdata_o` holds its last value when not reading.
- Back-to-back accesses on consecutive cycles are supported, with no stall.
- `t_intr_o` is registered: `tp` true after edge n → `t_intr_o`=1 after edge n+1.
- `e_intr_o` = `ep` & `ext_en`, driven from flops with no combinational path from `ext_irq_i`. `ext_irq_i` first sampled high at edge k → `e_intr_o`=1 after edge k+2.
- `rst_i` low at any edge forces every register to its reset value at that edge, including mid-access and mid-prescale. There is no partial state. The first access is accepted at the edge after `rst_i` returns high.

## Structure
- Package `riscv_intr_pkg`:
  - Register index constants `MTIME_IDX`, `MTIMECMP_IDX`, `CTRL_IDX`, `PEND_IDX`
  - CTRL bit positions `TIMER_EN_BIT`, `EXT_EN_BIT`, prescale field LSB/MSB
  - PEND bit positions
  - Reset constant for `mtimecmp`
- Sub-module `intr_sync_edge`: 2-flop synchronizer plus rising-edge pulse, same clock and reset. It is instantiated once for `ext_irq_i`.
- Top-level contents: register file, prescaler/timer counter, compare, `ep` latch, read mux.

## Test plan
- Timer fire:
  - Stimulus: write `CTRL`=0x0000_0001 (`prescale`=0), then `MTIMECMP`=10.
  - Response: `t_intr_o` rises exactly 1 cycle after `mtime` reaches 10.
  - Then write `MTIMECMP`=100: `t_intr_o` falls on the next cycle.
- Prescale: `CTRL`=0x0000_0301 (`prescale`=3) → `mtime` increments every 4 cycles; reading `MTIME` after 40 cycles returns 10±1.
- Wrap: write `MTIME`=0xFFFF_FFFE with `MTIMECMP`=all ones.
  - `t_intr_o` asserts at 0xFFFF_FFFF.
  - After the wrap to 0, `t_intr_o` deasserts.
- External edge:
  - With `ext_en`=1, pulse `ext_irq_i` for 1 cycle → `e_intr_o`=1 two edges later, and it stays high.
  - `e_ack_i` pulse → `e_intr_o`=0 the next cycle.
  - With `ext_en`=0, the same pulse → no assertion.
- Collisions:
  - `ext_irq_i` edge coinciding with a `PEND` W1C write (0x2) → `ep` remains 1.
  - `MTIME` write coinciding with a tick → `MTIME` reads back the written value.
- Reset mid-operation: drive `rst_i` low while `t_intr_o`=1 and `ep`=1.
  - Next edge: all outputs 0, `MTIMECMP` reads 0xFFFF_FFFF, `CTRL` reads 0.

Source files
------------

// File: rtl/riscv_intr_pkg.sv
// Register map, CTRL/PEND field layout and reset constants for the timer/interrupt controller.
package riscv_intr_pkg;

    localparam logic [1:0] MTIME_IDX    = 2'd0;
    localparam logic [1:0] MTIMECMP_IDX = 2'd1;
    localparam logic [1:0] CTRL_IDX     = 2'd2;
    localparam logic [1:0] PEND_IDX     = 2'd3;

    localparam int unsigned TIMER_EN_BIT = 0;
    localparam int unsigned EXT_EN_BIT   = 1;
    localparam int unsigned PRESCALE_LSB = 8;
    localparam int unsigned PRESCALE_MSB = 15;
    localparam int unsigned PRESCALE_W   = PRESCALE_MSB - PRESCALE_LSB + 1;

    localparam int unsigned TP_BIT = 0;
    localparam int unsigned EP_BIT = 1;

    localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [PRESCALE_W-1:0] prescale;
        logic                  ext_en;
        logic                  timer_en;
    } ctrl_t;

    // CTRL as seen on the bus; every bit outside the defined fields reads 0.
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w                            = '0;
        w[TIMER_EN_BIT]              = c.timer_en;
        w[EXT_EN_BIT]                = c.ext_en;
        w[PRESCALE_MSB:PRESCALE_LSB] = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// Two-flop synchronizer for an asynchronous request, followed by a single-cycle rising-edge pulse.
module intr_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/riscv_intr_ctrl.sv
// Memory-mapped mtime/mtimecmp timer and latched external interrupt for the 3-stage RISC-V core.
module riscv_intr_ctrl
    import riscv_intr_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned ADDRW = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [DW-1:0]    rdata_o,
    output logic             rvalid_o,
    input  logic             ext_irq_i,
    input  logic             e_ack_i,
    output logic             t_intr_o,
    output logic             e_intr_o
);

    logic [DW-1:0]         mtime_q, mtime_d;
    logic [DW-1:0]         mtimecmp_q, mtimecmp_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  ep_q, ep_d;
    logic                  t_intr_q;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  rvalid_q;

    logic       wr;
    logic       rd;
    logic [1:0] idx;
    logic       tick;
    logic       tp;
    logic       ep_clr;
    logic       ext_rise;

    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDRW-1:4], addr_i[1:0]};

    intr_sync_edge u_ext_sync (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .async_in   (ext_irq_i),
        .rise_pulse (ext_rise)
    );

    assign wr   = sel_i & we_i;
    assign rd   = sel_i & ~we_i;
    assign idx  = addr_i[3:2];
    assign tick = ctrl_q.timer_en && (pcnt_q == ctrl_q.prescale);
    assign tp   = ctrl_q.timer_en && (mtime_q >= mtimecmp_q);

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        pcnt_d     = pcnt_q;
        ep_d       = ep_q;
        ep_clr     = 1'b0;

        if (ctrl_q.timer_en) begin
            if (tick) begin
                pcnt_d  = '0;
                mtime_d = mtime_q + DW'(1);
            end else begin
                pcnt_d = pcnt_q + PRESCALE_W'(1);
            end
        end

        // Bus writes are applied after the tick so a same-cycle MTIME write overrides it.
        if (wr) begin
            unique case (idx)
                MTIME_IDX:    mtime_d    = wdata_i;
                MTIMECMP_IDX: mtimecmp_d = wdata_i;
                CTRL_IDX: begin
                    ctrl_d.timer_en = wdata_i[TIMER_EN_BIT];
                    ctrl_d.ext_en   = wdata_i[EXT_EN_BIT];
                    ctrl_d.prescale = wdata_i[PRESCALE_MSB:PRESCALE_LSB];
                    pcnt_d          = '0;
                end
                PEND_IDX:     ep_clr = wdata_i[EP_BIT];
            endcase
        end

        // A new edge beats any clear in the same cycle so no request is dropped.
        if (ext_rise && ctrl_q.ext_en) begin
            ep_d = 1'b1;
        end else if (ep_clr || e_ack_i) begin
            ep_d = 1'b0;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            unique case (idx)
                MTIME_IDX:    rdata_d = mtime_q;
                MTIMECMP_IDX: rdata_d = mtimecmp_q;
                CTRL_IDX:     rdata_d = DW'(ctrl_word(ctrl_q));
                PEND_IDX: begin
                    rdata_d         = '0;
                    rdata_d[TP_BIT] = tp;
                    rdata_d[EP_BIT] = ep_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= DW'(MTIMECMP_RST);
            ctrl_q     <= '0;
            pcnt_q     <= '0;
            ep_q       <= 1'b0;
            t_intr_q   <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            pcnt_q     <= pcnt_d;
            ep_q       <= ep_d;
            t_intr_q   <= tp;
            rdata_q    <= rdata_d;
            rvalid_q   <= rd;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign t_intr_o = t_intr_q;
    assign e_intr_o = ep_q & ctrl_q.ext_en;

endmodule

// File: tb/tb_riscv_intr_ctrl.sv
// Scoreboard bench for riscv_intr_ctrl: bus reads are queued with expected data, interrupts checked per cycle.
module tb_riscv_intr_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned ADDRW = 12;

    logic             clk;
    logic             rst_i;
    logic             sel_i;
    logic             we_i;
    logic [ADDRW-1:0] addr_i;
    logic [DW-1:0]    wdata_i;
    logic [DW-1:0]    rdata_o;
    logic             rvalid_o;
    logic             ext_irq_i;
    logic             e_ack_i;
    logic             t_intr_o;
    logic             e_intr_o;

    riscv_intr_ctrl #(
        .DW    (DW),
        .ADDRW (ADDRW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .sel_i     (sel_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .rvalid_o  (rvalid_o),
        .ext_irq_i (ext_irq_i),
        .e_ack_i   (e_ack_i),
        .t_intr_o  (t_intr_o),
        .e_intr_o  (e_intr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          ranged;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Ranged entries accept exp-1..exp+1.
    always @(negedge clk) begin
        if (rvalid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("rvalid_unexpected", 32'(rvalid_o), 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.ranged) begin
                    check_eq(e.tag, 32'((rdata_o + 32'd1 >= e.exp) && (rdata_o <= e.exp + 32'd1)),
                             32'd1);
                end else begin
                    check_eq(e.tag, rdata_o, e.exp);
                end
            end
        end
    end

    function automatic logic [ADDRW-1:0] reg_addr(input logic [1:0] idx);
        return {8'hA5, idx, 2'b01};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
        sel_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = reg_addr(idx);
        wdata_i = data;
        step();
        sel_i   = 1'b0;
        we_i    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] idx, input logic [31:0] exp, input string tag,
                            input bit ranged);
        sb_t e;
        e.tag    = tag;
        e.exp    = exp;
        e.ranged = ranged;
        sb_q.push_back(e);
        sel_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = reg_addr(idx);
        step();
        sel_i  = 1'b0;
    endtask

    task automatic pulse_ext();
        ext_irq_i = 1'b1;
        step();
        ext_irq_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i     = 1'b0;
        sel_i     = 1'b0;
        we_i      = 1'b0;
        addr_i    = '0;
        wdata_i   = '0;
        ext_irq_i = 1'b0;
        e_ack_i   = 1'b0;
        repeat (3) step();
        check_eq("rst_rvalid", 32'(rvalid_o), 32'd0);
        check_eq("rst_rdata", rdata_o, 32'd0);
        check_eq("rst_t_intr", 32'(t_intr_o), 32'd0);
        check_eq("rst_e_intr", 32'(e_intr_o), 32'd0);
        rst_i = 1'b1;

        bus_read(2'd1, 32'hFFFF_FFFF, "rst_mtimecmp", 1'b0);
        bus_read(2'd2, 32'h0, "rst_ctrl", 1'b0);
        bus_read(2'd0, 32'h0, "rst_mtime", 1'b0);
        bus_read(2'd3, 32'h0, "rst_pend", 1'b0);

        // Timer fire: first tick at the MTIMECMP write edge, so mtime==10 after the 10th edge.
        bus_write(2'd2, 32'h0000_0001);
        bus_write(2'd1, 32'd10);
        for (int n = 2; n <= 11; n++) begin
            step();
            if (n == 10) check_eq("t_intr_before", 32'(t_intr_o), 32'd0);
        end
        check_eq("t_intr_fire", 32'(t_intr_o), 32'd1);
        bus_write(2'd1, 32'd100);
        check_eq("t_intr_hold", 32'(t_intr_o), 32'd1);
        step();
        check_eq("t_intr_fall", 32'(t_intr_o), 32'd0);

        // Prescale 3: one increment every 4 cycles.
        bus_write(2'd2, 32'h0000_0301);
        bus_write(2'd0, 32'd0);
        repeat (40) step();
        bus_read(2'd0, 32'd10, "prescale_mtime", 1'b1);
        bus_read(2'd2, 32'h0000_0301, "ctrl_readback", 1'b0);

        // Wrap through 0xFFFF_FFFF.
        bus_write(2'd2, 32'h0000_0001);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd0, 32'hFFFF_FFFE);
        step();
        check_eq("wrap_pre", 32'(t_intr_o), 32'd0);
        step();
        check_eq("wrap_fire", 32'(t_intr_o), 32'd1);
        step();
        check_eq("wrap_clear", 32'(t_intr_o), 32'd0);

        // With prescale 0 every cycle ticks, so this write collides with a tick.
        bus_write(2'd0, 32'h0000_1234);
        bus_read(2'd0, 32'h0000_1234, "mtime_write_wins", 1'b0);

        // External edge with ext_en=1.
        bus_write(2'd2, 32'h0000_0002);
        pulse_ext();
        check_eq("ext_k", 32'(e_intr_o), 32'd0);
        step();
        check_eq("ext_k1", 32'(e_intr_o), 32'd0);
        step();
        check_eq("ext_k2", 32'(e_intr_o), 32'd1);
        repeat (3) step();
        check_eq("ext_stay", 32'(e_intr_o), 32'd1);
        bus_read(2'd3, 32'h2, "pend_ep", 1'b0);
        e_ack_i = 1'b1;
        step();
        e_ack_i = 1'b0;
        check_eq("ext_ack", 32'(e_intr_o), 32'd0);

        // Edges are dropped while ext_en=0.
        bus_write(2'd2, 32'h0000_0000);
        pulse_ext();
        repeat (4) step();
        check_eq("ext_dis", 32'(e_intr_o), 32'd0);
        bus_read(2'd3, 32'h0, "pend_dis", 1'b0);

        // Edge reaching ep in the same cycle as a PEND W1C.
        bus_write(2'd2, 32'h0000_0002);
        pulse_ext();
        step();
        bus_write(2'd3, 32'h0000_0002);
        check_eq("ep_set_wins", 32'(e_intr_o), 32'd1);
        bus_read(2'd3, 32'h2, "pend_collide", 1'b0);
        bus_write(2'd3, 32'h0000_0002);
        bus_read(2'd3, 32'h0, "pend_w1c", 1'b0);

        // Reset mid-operation with both interrupts pending and a read in flight.
        bus_write(2'd2, 32'h0000_0003);
        bus_write(2'd1, 32'd5);
        pulse_ext();
        repeat (3) step();
        check_eq("pre_rst_t", 32'(t_intr_o), 32'd1);
        check_eq("pre_rst_e", 32'(e_intr_o), 32'd1);
        rst_i  = 1'b0;
        sel_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = reg_addr(2'd0);
        step();
        sel_i  = 1'b0;
        check_eq("mid_rst_t", 32'(t_intr_o), 32'd0);
        check_eq("mid_rst_e", 32'(e_intr_o), 32'd0);
        check_eq("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
        check_eq("mid_rst_rdata", rdata_o, 32'd0);
        rst_i = 1'b1;
        bus_read(2'd1, 32'hFFFF_FFFF, "post_rst_mtimecmp", 1'b0);
        bus_read(2'd2, 32'h0, "post_rst_ctrl", 1'b0);
        bus_read(2'd0, 32'h0, "post_rst_mtime", 1'b0);
        bus_read(2'd3, 32'h0, "post_rst_pend", 1'b0);

        repeat (3) step();
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
